// File: rtl/register_file_8.sv
// 8 x N register file with one-hot write decode, busy scoreboard and two async read ports.
// Define REG_BYPASS_EN to forward same-cycle writeback data and busy onto the read ports.

module decoder_3_to_8 (
  input  logic       en_i,
  input  logic [2:0] addr_i,
  output logic [7:0] dec_o
);

  always_comb begin
    dec_o = 8'b0;
    if (en_i) begin
      dec_o[addr_i] = 1'b1;
    end
  end

endmodule

module register_file_8 #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_ena,
  input  logic [2:0]   wr_addr,
  input  logic [N-1:0] wr_data,
  input  logic         mark_ena,
  input  logic [2:0]   mark_addr,
  input  logic [2:0]   rd_addr0,
  input  logic [2:0]   rd_addr1,
  output logic [N-1:0] rd_data0,
  output logic [N-1:0] rd_data1,
  output logic         rd_busy0,
  output logic         rd_busy1
);

  logic [7:0]   wr_hit;
  logic [7:0]   mark_hit;
  logic [N-1:0] regs_q [8];
  logic [N-1:0] regs_d [8];
  logic [7:0]   busy_q;
  logic [7:0]   busy_d;

  decoder_3_to_8 u_wr_dec (
    .en_i   (wr_ena),
    .addr_i (wr_addr),
    .dec_o  (wr_hit)
  );

  decoder_3_to_8 u_mark_dec (
    .en_i   (mark_ena),
    .addr_i (mark_addr),
    .dec_o  (mark_hit)
  );

  // Mark is applied after write so a new producer wins over the retiring one.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < 8; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_hit[i]) begin
        regs_d[i] = wr_data;
        busy_d[i] = 1'b0;
      end
      if (mark_hit[i]) begin
        busy_d[i] = 1'b1;
      end
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= 8'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rd_data0 = regs_q[rd_addr0];
    rd_busy0 = busy_q[rd_addr0];
    rd_data1 = regs_q[rd_addr1];
    rd_busy1 = busy_q[rd_addr1];
`ifdef REG_BYPASS_EN
    if (wr_hit[rd_addr0] && (rd_addr0 != 3'd0)) begin
      rd_data0 = wr_data;
      rd_busy0 = mark_hit[rd_addr0];
    end
    if (wr_hit[rd_addr1] && (rd_addr1 != 3'd0)) begin
      rd_data1 = wr_data;
      rd_busy1 = mark_hit[rd_addr1];
    end
`endif
  end

endmodule

// File: tb/tb_register_file_8.sv
// Randomised self-checking bench for register_file_8 against an array-based reference model.
// Honours REG_BYPASS_EN in the model when the macro is defined for the build.

module tb_register_file_8;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_ena;
  logic [2:0]   wr_addr;
  logic [N-1:0] wr_data;
  logic         mark_ena;
  logic [2:0]   mark_addr;
  logic [2:0]   rd_addr0;
  logic [2:0]   rd_addr1;
  logic [N-1:0] rd_data0;
  logic [N-1:0] rd_data1;
  logic         rd_busy0;
  logic         rd_busy1;

  logic [N-1:0] m_regs [8];
  bit           m_busy [8];
  int           n_tests = 0;
  int           n_fail  = 0;

  always #5 clk = ~clk;

  register_file_8 #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_ena    (wr_ena),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .mark_ena  (mark_ena),
    .mark_addr (mark_addr),
    .rd_addr0  (rd_addr0),
    .rd_addr1  (rd_addr1),
    .rd_data0  (rd_data0),
    .rd_data1  (rd_data1),
    .rd_busy0  (rd_busy0),
    .rd_busy1  (rd_busy1)
  );

  task automatic check_eq(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] exp_data(input logic [2:0] a);
`ifdef REG_BYPASS_EN
    if (wr_ena && wr_addr == a && a != 3'd0) return wr_data;
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [2:0] a);
`ifdef REG_BYPASS_EN
    if (wr_ena && wr_addr == a && a != 3'd0) return mark_ena && mark_addr == a;
`endif
    return m_busy[a];
  endfunction

  task automatic set_in(input logic r, input logic we, input logic [2:0] wa,
                        input logic [N-1:0] wd, input logic me, input logic [2:0] ma,
                        input logic [2:0] a0, input logic [2:0] a1);
    rst = r; wr_ena = we; wr_addr = wa; wr_data = wd;
    mark_ena = me; mark_addr = ma; rd_addr0 = a0; rd_addr1 = a1;
  endtask

  // Called at negedge with inputs applied; optionally checks, then clocks the model.
  task automatic step(input bit do_chk);
    #1;
    if (do_chk) begin
      check_eq("rd_data0", rd_data0, exp_data(rd_addr0));
      check_eq("rd_data1", rd_data1, exp_data(rd_addr1));
      check_eq("rd_busy0", {31'b0, rd_busy0}, {31'b0, exp_busy(rd_addr0)});
      check_eq("rd_busy1", {31'b0, rd_busy1}, {31'b0, exp_busy(rd_addr1)});
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (wr_ena && wr_addr != 3'd0) begin
        m_regs[wr_addr] = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (mark_ena && mark_addr != 3'd0) m_busy[mark_addr] = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    step(0);

    // Preload then reset: every address must read zero and not busy.
    for (int i = 1; i < 8; i++) begin
      set_in(0, 1, 3'(i), $urandom, 1, 3'(8 - i), 0, 0);
      step(1);
    end
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    step(1);
    for (int a = 0; a < 8; a++) begin
      set_in(0, 0, 0, 0, 0, 0, 3'(a), 3'(7 - a));
      #1 check_eq("reset_data", rd_data0, 32'h0);
      check_eq("reset_busy", {31'b0, rd_busy0}, 32'h0);
      step(1);
    end

    set_in(0, 1, 5, 32'hDEADBEEF, 0, 0, 1, 1);
    step(1);
    set_in(0, 0, 0, 0, 0, 0, 5, 0);
    #1 check_eq("wr_r5", rd_data0, 32'hDEADBEEF);
    step(1);

    set_in(0, 1, 3, 32'h12345678, 0, 0, 0, 0);
    step(1);
    set_in(0, 0, 0, 0, 0, 0, 3, 3);
    #1 check_eq("r3_port0", rd_data0, 32'h12345678);
    check_eq("r3_port1", rd_data1, 32'h12345678);
    step(1);

    set_in(0, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
    step(1);
    #1 check_eq("r0_data", rd_data0, 32'h0);
    check_eq("r0_busy", {31'b0, rd_busy0}, 32'h0);

    set_in(0, 0, 0, 0, 1, 4, 0, 4);
    step(1);
    #1 check_eq("mark_r4_busy", {31'b0, rd_busy1}, 32'h1);
    set_in(0, 1, 4, 32'h55, 0, 0, 4, 4);
    step(1);
    set_in(0, 0, 0, 0, 0, 0, 4, 4);
    #1 check_eq("wr_r4_data", rd_data0, 32'h55);
    check_eq("wr_r4_busy", {31'b0, rd_busy0}, 32'h0);
    set_in(0, 1, 4, 32'h66, 1, 4, 1, 1);
    step(1);
    set_in(0, 0, 0, 0, 0, 0, 4, 4);
    #1 check_eq("mark_wr_data", rd_data0, 32'h66);
    check_eq("mark_wr_busy", {31'b0, rd_busy0}, 32'h1);
    step(1);

    set_in(0, 1, 2, 32'hA5A5A5A5, 0, 0, 2, 1);
`ifdef REG_BYPASS_EN
    #1 check_eq("bypass_same", rd_data0, 32'hA5A5A5A5);
`else
    #1 check_eq("bypass_same", rd_data0, 32'h0);
`endif
    step(1);
    set_in(0, 0, 0, 0, 0, 0, 2, 1);
    #1 check_eq("bypass_next", rd_data0, 32'hA5A5A5A5);
    step(1);

    set_in(1, 1, 6, 32'h77, 1, 6, 6, 6);
    step(1);
    set_in(0, 0, 0, 0, 0, 0, 6, 6);
    #1 check_eq("prio_data", rd_data0, 32'h0);
    check_eq("prio_busy", {31'b0, rd_busy1}, 32'h0);
    step(1);

    for (int k = 0; k < 400; k++) begin
      set_in(($urandom_range(0, 31) == 0), 1'($urandom), 3'($urandom), $urandom,
             1'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
      step(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
